// File: rtl/ps2_kb_pkg.sv
// Shared definitions for the PS/2 keyboard controller: receive FSM states,
// status-register bit positions and default parameter values.
package ps2_kb_pkg;

   localparam int DEF_FIFO_DEPTH     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 2000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   localparam int SB_NE   = 0;
   localparam int SB_FULL = 1;
   localparam int SB_OVF  = 2;
   localparam int SB_PERR = 3;
   localparam int SB_FERR = 4;

endpackage

// File: rtl/ps2_kb_fifo.sv
// Synchronous scan-code FIFO with occupancy count; head is the oldest entry.
module kb_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // push/pop are single-cycle requests with no ready: a push into a full FIFO
   // is taken only if a pop frees the slot in the same cycle, and a pop of an
   // empty FIFO is taken only if a push fills it in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & (~empty | push);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard receiver with scan-code FIFO and a two-register CPU read port
// (data / status) plus an active-low interrupt.
module ps2_kb_controller
   import ps2_kb_pkg::*;
#(
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KB_CLK,
   input  logic       KB_DATA,
   input  logic       CS,
   input  logic       RD,
   input  logic       A0,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   output logic       INT,
   output rx_state_e  fsm_state
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   logic rst_meta, rst_sync;
   logic kc_s1, kc_s2, kc_prev, kd_s1, kd_s2;
   logic fall, sample;

   rx_state_e     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_good;
   logic [TW-1:0] to_cnt;
   logic          push_req, perr_set, ferr_set;

   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;

   logic          active, active_q, a0_q, sel_a0, trailing, pop_req, st_clr;
   logic [7:0]    data_now, data_hold, status;
   logic          ovf, perr, ferr, ovf_set, int_n;

   // Asynchronous assertion, synchronous release of the internal reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) {rst_meta, rst_sync} <= 2'b00;
      else      {rst_meta, rst_sync} <= {1'b1, rst_meta};
   end

   always_ff @(posedge CLK or negedge rst_sync) begin
      if (!rst_sync) begin
         {kc_s1, kc_s2, kc_prev} <= 3'b111;
         {kd_s1, kd_s2}          <= 2'b11;
      end else begin
         {kc_s1, kc_s2, kc_prev} <= {KB_CLK, kc_s1, kc_s2};
         {kd_s1, kd_s2}          <= {KB_DATA, kd_s1};
      end
   end

   assign fall   = kc_prev & ~kc_s2;
   assign sample = kd_s2;

   always_ff @(posedge CLK or negedge rst_sync) begin
      if (!rst_sync) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_good <= 1'b0;
         to_cnt   <= '0;
         push_req <= 1'b0;
         perr_set <= 1'b0;
         ferr_set <= 1'b0;
      end else begin
         push_req <= 1'b0;
         perr_set <= 1'b0;
         ferr_set <= 1'b0;
         if (state != ST_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES-1)) begin
            state    <= ST_IDLE;
            to_cnt   <= '0;
            ferr_set <= 1'b1;
         end else begin
            to_cnt <= (state == ST_IDLE || fall) ? '0 : to_cnt + TW'(1);
            if (fall) begin
               case (state)
                  ST_IDLE: begin
                     if (!sample) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                     end
                  end
                  ST_DATA: begin
                     shreg   <= {sample, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) state <= ST_PARITY;
                  end
                  ST_PARITY: begin
                     par_good <= ^{shreg, sample};
                     state    <= ST_STOP;
                  end
                  ST_STOP: begin
                     if (!sample)        ferr_set <= 1'b1;
                     else if (par_good)  push_req <= 1'b1;
                     else                perr_set <= 1'b1;
                     state <= ST_IDLE;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign fsm_state = state;

   kb_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .CLK   (CLK),
      .RST   (rst_sync),
      .push  (push_req),
      .pop   (pop_req),
      .din   (shreg),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign active   = ~CS & ~RD;
   assign D_OE     = active;
   assign trailing = active_q & ~active;
   assign pop_req  = trailing & ~a0_q;
   assign st_clr   = trailing & a0_q;
   assign data_now = fifo_empty ? 8'h00 : fifo_head;
   assign sel_a0   = active_q ? a0_q : A0;
   assign ovf_set  = push_req & (fifo_count == CW'(FIFO_DEPTH)) & ~pop_req;

   always_comb begin
      status          = '0;
      status[SB_NE]   = ~fifo_empty;
      status[SB_FULL] = fifo_full;
      status[SB_OVF]  = ovf;
      status[SB_PERR] = perr;
      status[SB_FERR] = ferr;
   end

   // Data is frozen at access start so a push into an empty FIFO cannot
   // change the byte mid-read; status stays live.
   assign D_OUT = sel_a0 ? status : (active_q ? data_hold : data_now);

   always_ff @(posedge CLK or negedge rst_sync) begin
      if (!rst_sync) begin
         active_q  <= 1'b0;
         a0_q      <= 1'b0;
         data_hold <= '0;
         ovf       <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         int_n     <= 1'b1;
      end else begin
         active_q <= active;
         if (active) a0_q <= A0;
         if (active && !active_q) data_hold <= data_now;
         ovf   <= ovf_set  | (ovf  & ~st_clr);
         perr  <= perr_set | (perr & ~st_clr);
         ferr  <= ferr_set | (ferr & ~st_clr);
         int_n <= ~(~fifo_empty | ovf | perr | ferr);
      end
   end

   assign INT = int_n;

endmodule

// File: tb/tb_ps2_kb_controller.sv
// Directed bench for ps2_kb_controller: table of single-frame cases plus
// hand-written sequences for ordering, overflow, timeout and reset.
module tb_ps2_kb_controller;
   import ps2_kb_pkg::*;

   localparam int HALF = 8;
   localparam int TO   = 100;

   logic       clk = 1'b0;
   logic       rst, kb_clk, kb_data, cs, rd, a0;
   logic [7:0] d_out;
   logic       d_oe, int_n;
   rx_state_e  fsm_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       flip_par;
      logic       stop_bit;
      logic [7:0] exp_st;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   ps2_kb_controller #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
      .CLK       (clk),
      .RST       (rst),
      .KB_CLK    (kb_clk),
      .KB_DATA   (kb_data),
      .CS        (cs),
      .RD        (rd),
      .A0        (a0),
      .D_OUT     (d_out),
      .D_OE      (d_oe),
      .INT       (int_n),
      .fsm_state (fsm_state)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      kb_data = b;
      repeat (HALF) @(negedge clk);
      kb_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      kb_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic flip_par, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(~(^data) ^ flip_par);
      send_bit(stop_bit);
      repeat (10) @(negedge clk);
   endtask

   task automatic read_check(input string name, input logic sel, input logic [7:0] exp);
      logic [7:0] d;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0; a0 = sel;
      repeat (2) @(negedge clk);
      d = d_out;
      check({name, "_oe"}, {7'b0, d_oe}, 8'h01);
      check(name, d, exp);
      cs = 1'b1; rd = 1'b1; a0 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h01, 8'h1C};
      vecs[1] = '{8'hF0, 1'b0, 1'b1, 8'h01, 8'hF0};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h01, 8'h00};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'h01, 8'hFF};
      vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'h01, 8'hA5};
      vecs[5] = '{8'h1C, 1'b1, 1'b1, 8'h08, 8'h00};
      vecs[6] = '{8'h5A, 1'b0, 1'b0, 8'h10, 8'h00};
      vecs[7] = '{8'h33, 1'b1, 1'b0, 8'h10, 8'h00};

      rst = 1'b0; kb_clk = 1'b1; kb_data = 1'b1; cs = 1'b1; rd = 1'b1; a0 = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      check("rst_int", {7'b0, int_n}, 8'h01);
      check("rst_oe", {7'b0, d_oe}, 8'h00);
      check("rst_fsm", {6'b0, fsm_state}, {6'b0, ST_IDLE});
      read_check("rst_status", 1'b1, 8'h00);
      read_check("rst_data", 1'b0, 8'h00);

      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].stop_bit);
         check($sformatf("v%0d_int_low", i), {7'b0, int_n}, 8'h00);
         read_check($sformatf("v%0d_status", i), 1'b1, vecs[i].exp_st);
         read_check($sformatf("v%0d_data", i), 1'b0, vecs[i].exp_rd);
         read_check($sformatf("v%0d_status_after", i), 1'b1, 8'h00);
         check($sformatf("v%0d_int_high", i), {7'b0, int_n}, 8'h01);
      end

      // Two frames back to back come out in arrival order.
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      read_check("seq2_rd0", 1'b0, 8'hF0);
      read_check("seq2_rd1", 1'b0, 8'h1C);
      read_check("seq2_rd2", 1'b0, 8'h00);
      read_check("seq2_status", 1'b1, 8'h00);
      check("seq2_int", {7'b0, int_n}, 8'h01);

      // Nine frames into an eight-entry FIFO: the ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         send_frame(8'h41 + 8'(i * 7), 1'b0, 1'b1);
         if (i < 8) exp_q.push_back(8'h41 + 8'(i * 7));
      end
      check("ovf_int", {7'b0, int_n}, 8'h00);
      read_check("ovf_status", 1'b1, 8'h07);
      for (int i = 0; i < 8; i++) begin
         read_check($sformatf("ovf_rd%0d", i), 1'b0, exp_q.pop_front());
         if (i == 0) read_check("ovf_status_after1", 1'b1, 8'h01);
      end
      read_check("ovf_rd_empty", 1'b0, 8'h00);
      read_check("ovf_status_end", 1'b1, 8'h00);
      check("ovf_int_end", {7'b0, int_n}, 8'h01);

      // Partial frame abandoned after TO cycles without a falling edge.
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      repeat (40) @(negedge clk);
      check("to_busy", {7'b0, fsm_state == ST_IDLE}, 8'h00);
      repeat (70) @(negedge clk);
      check("to_idle", {6'b0, fsm_state}, {6'b0, ST_IDLE});
      check("to_int", {7'b0, int_n}, 8'h00);
      read_check("to_status", 1'b1, 8'h10);
      read_check("to_status_clr", 1'b1, 8'h00);
      send_frame(8'h3A, 1'b0, 1'b1);
      read_check("to_next_rd", 1'b0, 8'h3A);
      read_check("to_next_status", 1'b1, 8'h00);

      // Reset in the middle of a frame abandons it without side effects.
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("mrst_fsm", {6'b0, fsm_state}, {6'b0, ST_IDLE});
      check("mrst_int", {7'b0, int_n}, 8'h01);
      read_check("mrst_status", 1'b1, 8'h00);
      send_frame(8'h66, 1'b0, 1'b1);
      read_check("mrst_next_rd", 1'b0, 8'h66);
      read_check("mrst_next_status", 1'b1, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_kb_controller.md
PS2_KB_CONTROLLER -- requirements
Module: ps2_kb_controller

Interface
REQ-001 Parameter FIFO_DEPTH, 8, number of scan-code entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, 2000, CLK cycles without a KB_CLK falling edge before a partial frame is abandoned.
REQ-003 CLK  in  1  system clock; the block has one clock, and all logic is clocked on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 KB_CLK  in  1  PS/2 clock line, asynchronous to CLK.
REQ-006 KB_DATA  in  1  PS/2 data line, asynchronous to CLK.
REQ-007 CS  in  1  I/O chip select from the address decode, active-low.
REQ-008 RD  in  1  CPU read strobe, active-low.
REQ-009 A0  in  1  register select: 0 = data, 1 = status.
REQ-010 D_OUT  out  8  read data; the top level drives the tri-state buffer.
REQ-011 D_OE  out  1  read-data enable, active-high.
REQ-012 INT  out  1  interrupt to the CPU, active-low.

Function
REQ-013 KB_CLK and KB_DATA SHALL each pass through a 2-flop synchronizer; a KB_CLK falling edge is synced-previous=1 and synced-current=0, and KB_DATA SHALL be sampled on that cycle.
REQ-014 The receive FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL advance only on KB_CLK falling edges, except on timeout (REQ-019).
REQ-015 IDLE: a sample of 0 (start bit) SHALL go to DATA with the bit counter cleared; a sample of 1 SHALL stay in IDLE with no flag set.
REQ-016 DATA: the FSM SHALL shift the sample in LSB-first and go to PARITY after the 8th bit.
REQ-017 PARITY: the FSM SHALL record whether the 8 data bits plus the sample have an odd number of ones (parity good), then go to STOP.
REQ-018 STOP: with sample=1 and parity good, the FSM SHALL push the byte; with sample=0, it SHALL set FERR and discard the byte; with sample=1 and parity bad, it SHALL set PERR and discard the byte; in every case it SHALL return to IDLE.
REQ-019 Outside IDLE, a cycle counter SHALL clear on each falling edge; when it reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, set FERR and discard the partial byte.
REQ-020 In IDLE the counter SHALL hold at 0.
REQ-021 The push SHALL write the FIFO on the cycle after the STOP edge.
REQ-022 If the FIFO is full at push time, the byte SHALL be dropped and OVF set, leaving the FIFO contents unchanged.
REQ-023 D_OE SHALL equal (~CS & ~RD), combinationally.
REQ-024 With A0=0, D_OUT SHALL be the FIFO head, or 0x00 when the FIFO is empty.
REQ-025 With A0=1, D_OUT SHALL be the status byte: bit0 NE (not empty), bit1 FULL, bit2 OVF, bit3 PERR, bit4 FERR, bits7:5 = 0.
REQ-026 A read access is the active interval of (~CS & ~RD), registered once; A0 SHALL be latched while the access is active.
REQ-027 At the trailing edge of an access (registered active=1, current active=0), a data access SHALL pop one entry if the FIFO is not empty; popping an empty FIFO SHALL have no effect.
REQ-028 At the trailing edge of a status access, OVF, PERR and FERR SHALL clear.
REQ-029 If an error event and the status-read clear fall on the same cycle, the set SHALL win.
REQ-030 A push and a pop on the same cycle SHALL both take effect, with the count unchanged; this includes the full and empty cases.
REQ-031 The FIFO count SHALL range from 0 to FIFO_DEPTH; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 INT SHALL be low whenever NE=1 or any sticky flag is set, and registered.
REQ-033 D_OUT SHALL remain stable for the whole of an access, except that the status bits update live.

Reset
REQ-034 While RST=0, the block SHALL asynchronously force: FSM to IDLE, bit counter, timeout counter, shift register, FIFO pointers and count to 0, OVF/PERR/FERR to 0, synchronizers to 1, INT=1 and the access registers inactive.
REQ-035 A reset asserted mid-frame or mid-access SHALL abandon it, with no push, no pop and no flag set.
REQ-036 Reset deassertion SHALL be synchronized to CLK before it reaches the FSM.

Structure
REQ-037 A shared package ps2_kb_pkg SHALL hold the FSM state enum, the status-bit index constants and the default parameter values.
REQ-038 Storage SHALL be one sub-module, kb_fifo (synchronous FIFO: push, pop, head, count, full, empty).
REQ-039 The FSM, synchronizers, timeout and bus logic SHALL reside in ps2_kb_controller.

Verification
REQ-040 Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> status 0x01, INT low; data read returns 0x1C; after the read, status 0x00 and INT high.
REQ-041 Frames 0xF0 (parity 1), then 0x1C -> reads return 0xF0 then 0x1C, and a third read returns 0x00 with status 0x00.
REQ-042 Frame 0x1C with parity bit 1 -> no push; status 0x08; after the status read, status 0x00.
REQ-043 Nine good frames with FIFO_DEPTH=8 -> status 0x07; reads return the first 8 bytes in order; the 9th byte is lost.
REQ-044 Start bit plus 4 data bits, then KB_CLK held high for TIMEOUT_CYCLES -> FSM returns to IDLE, status 0x10; a following full frame is received correctly.
REQ-045 RST pulsed low after the 6th bit of a frame -> status 0x00, INT high; the next complete frame is received correctly.
